// File: rtl/prog_counter3_if.sv
// Fetch-stage PC request/response bundle: redirect requests in, fetch address and RAS flags out.
// Addresses use [0:WIDTH-1] numbering, so bit 0 is the MSB.
interface prog_counter3_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             br_en;
   logic             call;
   logic             ret;
   logic [0:WIDTH-1] br_tgt;
   logic [0:WIDTH-1] pc;
   logic [0:WIDTH-1] next_pc;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_err;

   modport master (
      output stall, br_en, call, ret, br_tgt,
      input  pc, next_pc, ras_empty, ras_full, ras_err
   );

   modport slave (
      input  stall, br_en, call, ret, br_tgt,
      output pc, next_pc, ras_empty, ras_full, ras_err
   );
endinterface

// File: rtl/prog_counter3.sv
// Fetch program counter with stall, branch load and a call/return stack.
// The return-address stack is built only when PC_RAS_EN is defined.
module prog_counter3 #(
   parameter int WIDTH     = 32,
   parameter int STEP      = 4,
   parameter int RESET_VEC = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   prog_counter3_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);

   logic [0:WIDTH-1] pc_q, pc_d;
   logic [0:WIDTH-1] seq;

   assign seq         = pc_q + WIDTH'(STEP);
   assign bus.pc      = pc_q;
   assign bus.next_pc = rst ? WIDTH'(RESET_VEC) : pc_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= WIDTH'(RESET_VEC);
      else     pc_q <= pc_d;
   end

`ifdef PC_RAS_EN
   // Circular LIFO: top_q indexes the newest entry, so a push into a full
   // stack lands on the oldest slot and discards it.
   logic [0:WIDTH-1] ras_q [RAS_DEPTH];
   logic [PW-1:0]    top_q, top_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             push;
   logic             full;

   assign full = (cnt_q == (PW+1)'(RAS_DEPTH));

   always_comb begin
      pc_d  = seq;
      top_d = top_q;
      cnt_d = cnt_q;
      err_d = err_q;
      push  = 1'b0;
      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.ret) begin
         if (cnt_q != '0) begin
            pc_d  = ras_q[top_q];
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.call) begin
         pc_d  = bus.br_tgt;
         push  = 1'b1;
         top_d = top_q + PW'(1);
         if (full) err_d = 1'b1;
         else      cnt_d = cnt_q + (PW+1)'(1);
      end else if (bus.br_en) begin
         pc_d = bus.br_tgt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Entries are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge clk) begin
      if (push) ras_q[top_d] <= seq;
   end

   assign bus.ras_empty = (cnt_q == '0);
   assign bus.ras_full  = full;
   assign bus.ras_err   = err_q;
`else
   logic unused_ret;

   always_comb begin
      pc_d = seq;
      if (bus.stall)                   pc_d = pc_q;
      else if (bus.call || bus.br_en)  pc_d = bus.br_tgt;
   end

   assign unused_ret    = bus.ret ^ PW[0];
   assign bus.ras_empty = 1'b1;
   assign bus.ras_full  = 1'b0;
   assign bus.ras_err   = 1'b0;
`endif
endmodule

// File: tb/tb_prog_counter3.sv
// Self-checking bench for prog_counter3: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requests.
module tb_prog_counter3;
   localparam int WIDTH = 32;
   localparam int STEP  = 4;
   localparam int RV    = 200;
   localparam int DEPTH = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   prog_counter3_if #(.WIDTH(WIDTH)) bus ();

   prog_counter3 #(.WIDTH(WIDTH), .STEP(STEP), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: pc as a plain number, RAS as a queue (back = newest).
   logic [31:0] m_pc = 32'(RV);
   logic [31:0] ras [$];
   logic        m_err = 1'b0;

   function automatic logic [31:0] m_next();
      logic [31:0] seq;
      seq = m_pc + 32'(STEP);
      if (rst)                return 32'(RV);
      if (bus.stall)          return m_pc;
      if (RAS_EN && bus.ret)  return (ras.size() > 0) ? ras[$] : seq;
      if (bus.call || bus.br_en) return bus.br_tgt;
      return seq;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc  = 32'(RV);
         ras.delete();
         m_err = 1'b0;
      end else begin
         logic [31:0] nxt;
         nxt = m_next();
         if (!bus.stall) begin
            if (RAS_EN && bus.ret) begin
               if (ras.size() > 0) void'(ras.pop_back());
               else                m_err = 1'b1;
            end else if (RAS_EN && bus.call) begin
               ras.push_back(m_pc + 32'(STEP));
               if (ras.size() > DEPTH) begin
                  void'(ras.pop_front());
                  m_err = 1'b1;
               end
            end
         end
         m_pc = nxt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model; inputs never change at negedge.
   always @(negedge clk) begin
      check("pc", bus.pc, m_pc);
      check("next_pc", bus.next_pc, m_next());
      check("ras_empty", 32'(bus.ras_empty), 32'(ras.size() == 0));
      check("ras_full", 32'(bus.ras_full), 32'(ras.size() == DEPTH));
      check("ras_err", 32'(bus.ras_err), 32'(m_err));
   end

   task automatic drive(input logic s, input logic b, input logic [31:0] t,
                        input logic c, input logic r);
      #1;
      bus.stall  = s;
      bus.br_en  = b;
      bus.br_tgt = t;
      bus.call   = c;
      bus.ret    = r;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic s, input logic b, input logic [31:0] t,
                       input logic c, input logic r);
      drive(s, b, t, c, r);
      tick();
   endtask

   initial begin
      bus.stall = 0; bus.br_en = 0; bus.br_tgt = '0; bus.call = 0; bus.ret = 0;
      repeat (2) @(negedge clk);
      check("rst_pc", bus.pc, 200);
      check("rst_next", bus.next_pc, 200);
      check("rst_empty", 32'(bus.ras_empty), 1);
      check("rst_full", 32'(bus.ras_full), 0);
      check("rst_err", 32'(bus.ras_err), 0);
      #1 rst = 1'b0;
      check("rel_pc", bus.pc, 200);
      repeat (15) tick();
      check("count15", bus.pc, 260);

      // Stall and branch
      step(0, 1, 208, 0, 0);          check("br208", bus.pc, 208);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0);         check("stall", bus.pc, 208);
      end
      step(1, 1, 1000, 0, 0);         check("stall_br", bus.pc, 208);
      step(0, 1, 1000, 0, 0);         check("br1000", bus.pc, 1000);
      step(0, 0, 0, 0, 0);            check("seq1004", bus.pc, 1004);

      // Wrap-around
      step(0, 1, 32'hFFFF_FFFC, 0, 0); check("wrap_tgt", bus.pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0);             check("wrap0", bus.pc, 0);
      step(0, 0, 0, 0, 0);             check("wrap4", bus.pc, 4);

      // Asynchronous reset mid-cycle
      #3 rst = 1'b1;
      #1 check("async_rst_pc", bus.pc, 200);
      @(negedge clk);
      #1 rst = 1'b0;
      tick();                          check("post_rst", bus.pc, 204);

`ifdef PC_RAS_EN
      step(0, 1, 300, 0, 0);          check("at300", bus.pc, 300);
      step(0, 0, 500, 1, 0);          check("call500", bus.pc, 500);
      check("call_nonempty", 32'(bus.ras_empty), 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);            check("at508", bus.pc, 508);
      step(0, 0, 700, 1, 0);          check("call700", bus.pc, 700);
      step(0, 0, 0, 0, 1);            check("ret512", bus.pc, 512);
      step(0, 0, 0, 0, 1);            check("ret304", bus.pc, 304);
      check("ret_empty", 32'(bus.ras_empty), 1);
      check("ret_noerr", 32'(bus.ras_err), 0);

      // RAS boundaries: 5 calls from 304, 308 is overwritten
      for (int i = 1; i <= 4; i++) step(0, 0, 32'(1000 * i), 1, 0);
      check("full4", 32'(bus.ras_full), 1);
      check("noerr4", 32'(bus.ras_err), 0);
      step(0, 0, 5000, 1, 0);         check("call5", bus.pc, 5000);
      check("full5", 32'(bus.ras_full), 1);
      check("err5", 32'(bus.ras_err), 1);
      step(0, 0, 0, 0, 1);            check("pop4004", bus.pc, 4004);
      step(0, 0, 0, 0, 1);            check("pop3004", bus.pc, 3004);
      step(0, 0, 0, 0, 1);            check("pop2004", bus.pc, 2004);
      step(0, 0, 0, 0, 1);            check("pop1004", bus.pc, 1004);
      check("pop_empty", 32'(bus.ras_empty), 1);
      step(0, 0, 0, 0, 1);            check("underflow", bus.pc, 1008);
      step(0, 0, 9000, 1, 1);         check("callret_empty", bus.pc, 1012);
      step(0, 0, 6000, 1, 0);         check("call6000", bus.pc, 6000);
      step(0, 0, 7000, 1, 1);         check("callret", bus.pc, 1016);
      check("callret_empty_flag", 32'(bus.ras_empty), 1);
`else
      step(0, 0, 500, 1, 0);          check("call_as_br", bus.pc, 500);
      step(0, 0, 0, 0, 1);            check("ret_ignored", bus.pc, 504);
      check("norас_empty", 32'(bus.ras_empty), 1);
      check("noras_full", 32'(bus.ras_full), 0);
      check("noras_err", 32'(bus.ras_err), 0);
`endif

      // Randomized requests, with a fresh reset halfway through
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
         end
         step(($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0),
              {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 1) ? 32'hFFFF_FC00 : 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_counter3.md
# prog_counter3

Parametrised program counter for the Troy WideWord Processor fetch stage; successor to the fixed-increment counter. It holds the current fetch address and advances it by a configurable step each cycle. It also supports fetch stall, taken branch/jump load, and an optional hardware return-address stack (RAS) for call/return. It feeds the instruction memory address and the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, address width in bits; all address buses are [0:WIDTH-1], with bit 0 as MSB.
- STEP, 4, increment added for sequential fetch.
- RESET_VEC, 0, value of pc after reset.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2); unused without PC_RAS_EN.

Ports:
- clk  in  1  fetch clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold pc; ignores all other requests this cycle.
- br_en  in  1  taken branch/jump: load br_tgt.
- br_tgt  in  WIDTH  branch, jump or call target.
- call  in  1  subroutine call: load br_tgt and push return address.
- ret  in  1  subroutine return: load popped return address.
- pc  out  WIDTH  registered current fetch address.
- next_pc  out  WIDTH  combinational value pc will take at the next edge.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky flag set by RAS overflow or underflow; cleared only by rst.

## Operation
- Sequential address is seq = pc + STEP, truncated to WIDTH bits, so the address wraps from 2^WIDTH−STEP back to 0.
- next_pc is selected by the first matching request, in priority order:
  - stall: next_pc = pc.
  - ret: next_pc = RAS top, and the top entry is popped.
  - call: next_pc = br_tgt, and seq is pushed.
  - br_en: next_pc = br_tgt.
  - otherwise: next_pc = seq.
- A lower-priority request that arrives together with a higher one is dropped, not queued.
- The RAS is a circular LIFO with a top pointer and a count from 0 to RAS_DEPTH.
- Call while full:
  - The push still happens; the oldest entry is overwritten.
  - count stays at RAS_DEPTH.
  - ras_err is set.
- Ret while empty:
  - next_pc = seq, and the count is unchanged.
  - ras_err is set.
- call and ret in the same cycle: ret wins, call is ignored, and there is no push.
- A stalled cycle never changes the RAS or ras_err.
- br_en together with call is treated as call.

## Timing
- Reset (asynchronous, any time, including mid-call/ret):
  - pc = RESET_VEC.
  - RAS count = 0 and top pointer = 0; entries are don't-care.
  - ras_empty = 1, ras_full = 0, ras_err = 0.
  - next_pc is forced to RESET_VEC while rst is high.
- The first rising edge after rst falls loads next_pc, as computed from the inputs at that edge.
- next_pc has zero latency: it is combinational from pc, the requests, br_tgt and the RAS top.
- pc has a latency of one clock from any request.
- A redirect is visible on pc in the cycle after the request is asserted.
- RAS push/pop and the flags update on the same edge as pc.
- A popped value is available to a ret on the very next cycle.
- No handshake is involved: requests are single-cycle levels, sampled each edge.

## Configuration
- PC_RAS_EN defined:
  - RAS of RAS_DEPTH entries is instantiated.
  - call and ret behave as specified above.
- PC_RAS_EN undefined:
  - No RAS storage is built.
  - call behaves exactly as br_en, with no push.
  - ret is ignored, so next_pc = seq unless stall or br_en applies.
  - ras_empty is tied to 1, ras_full to 0, and ras_err to 0.

## Test plan
Settings: WIDTH=32, STEP=4, RESET_VEC=200, RAS_DEPTH=4, PC_RAS_EN defined unless stated.
- Reset and count: hold rst for 2 cycles, then release → pc reads 200, 204, 208 … and reaches 260 after 15 edges. Asserting rst mid-run → pc returns to 200 immediately, without waiting for clk.
- Stall and branch:
  - Stall with pc=208 for 3 cycles → pc stays 208.
  - br_en with br_tgt=1000 together with stall → pc stays 208.
  - Next cycle, br_en alone → pc = 1000, then 1004.
- Wrap-around: br_tgt=32'hFFFFFFFC, br_en → pc = FFFFFFFC, then 0, then 4.
- Call/return:
  - At pc=300, call with br_tgt=500 → pc = 500 and ras_empty = 0.
  - Nested call at 508 with br_tgt=700 → pc = 700.
  - ret → pc = 512; ret → pc = 304; ras_empty = 1; ras_err = 0.
- RAS boundaries:
  - 5 calls in a row → ras_full = 1 and ras_err = 1; the first return address is lost.
  - 4 rets → return addresses in LIFO order; a 5th ret → pc = seq.
  - call+ret in the same cycle → ret taken.
- Build without PC_RAS_EN:
  - call with br_tgt=500 → pc = 500.
  - ret → pc = 504.
  - ras_empty = 1, ras_full = 0, ras_err = 0 throughout.
